// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC1/PC2 tables, shift schedule, FSM states.
// Tables hold 1-based DES bit numbers; MSB-first vectors index them as [n-1].
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 28;
    localparam int SUBKEY_W = 48;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    localparam int PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT_SCHED [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Rotates both 28-bit halves by the amount scheduled for 'round'; right undoes left.
    function automatic logic [0:2*CD_W-1] rot_cd(input logic [0:2*CD_W-1] cd,
                                                 input logic [4:0]        round,
                                                 input logic              right);
        logic [0:CD_W-1] c;
        logic [0:CD_W-1] d;
        logic            two;
        c   = cd[0:CD_W-1];
        d   = cd[CD_W:2*CD_W-1];
        two = (SHIFT_SCHED[round] == 2);
        if (!right && !two) begin
            c = {c[1:CD_W-1], c[0]};
            d = {d[1:CD_W-1], d[0]};
        end else if (!right) begin
            c = {c[2:CD_W-1], c[0:1]};
            d = {d[2:CD_W-1], d[0:1]};
        end else if (!two) begin
            c = {c[CD_W-1], c[0:CD_W-2]};
            d = {d[CD_W-1], d[0:CD_W-2]};
        end else begin
            c = {c[CD_W-2:CD_W-1], c[0:CD_W-3]};
            d = {d[CD_W-2:CD_W-1], d[0:CD_W-3]};
        end
        return {c, d};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC2 compression permutation: 56-bit {C,D} to a 48-bit round subkey, pure wiring.
module des_pc2
    import des_pkg::*;
(
    input  logic [0:2*CD_W-1]   cd,
    output logic [0:SUBKEY_W-1] subkey
);

    for (genvar gi = 0; gi < SUBKEY_W; gi++) begin : g_pc2
        assign subkey[gi] = cd[PC2_TBL[gi] - 1];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: one 48-bit subkey per handshake, encrypt or
// decrypt order, with decrypt walking C/D backwards by right rotations.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                decrypt,
    input  logic [0:KEY_W-1]    key_in,
    input  logic                advance,
    output logic [0:SUBKEY_W-1] subkey_out,
    output logic                subkey_valid,
    output logic [3:0]          round_idx,
    output logic                busy,
    output logic                done
);

    localparam logic [4:0] LAST_STEP = 5'(NUM_ROUNDS);

    state_t                state_reg, state_next;
    logic [0:2*CD_W-1]     cd_reg, cd_next, pc1_cd;
    logic [4:0]            step_reg, step_next;
    logic [3:0]            idx_reg, idx_next;
    logic                  dec_reg, dec_next;
    logic [0:SUBKEY_W-1]   subkey_reg, pc2_sub;
    logic                  load_sub, clear_sub;
    logic [7:0]            unused_parity_bits;

    for (genvar gi = 0; gi < 2*CD_W; gi++) begin : g_pc1
        assign pc1_cd[gi] = key_in[PC1_TBL[gi] - 1];
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_parity
        assign unused_parity_bits[gi] = key_in[8*gi + 7];
    end

    // PC2 sits on the next-state value so the subkey registers alongside C/D.
    des_pc2 u_pc2 (
        .cd     (cd_next),
        .subkey (pc2_sub)
    );

    always_comb begin
        state_next = state_reg;
        cd_next    = cd_reg;
        step_next  = step_reg;
        idx_next   = idx_reg;
        dec_next   = dec_reg;
        load_sub   = 1'b0;
        clear_sub  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    dec_next   = decrypt;
                    step_next  = 5'd1;
                    idx_next   = decrypt ? 4'd15 : 4'd0;
                    cd_next    = decrypt ? pc1_cd : rot_cd(pc1_cd, 5'd1, 1'b0);
                    load_sub   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (advance) begin
                    if (step_reg != LAST_STEP) begin
                        step_next = step_reg + 5'd1;
                        load_sub  = 1'b1;
                        if (dec_reg) begin
                            cd_next  = rot_cd(cd_reg, 5'd17 - step_reg, 1'b1);
                            idx_next = idx_reg - 4'd1;
                        end else begin
                            cd_next  = rot_cd(cd_reg, step_reg + 5'd1, 1'b0);
                            idx_next = idx_reg + 4'd1;
                        end
                    end else begin
                        // Decrypt stops at C1/D1; the final undo of s[1] returns it to C0/D0.
                        if (dec_reg) begin
                            cd_next = rot_cd(cd_reg, 5'd1, 1'b1);
                        end
                        step_next  = 5'd0;
                        idx_next   = 4'd0;
                        clear_sub  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cd_reg     <= '0;
            step_reg   <= '0;
            idx_reg    <= '0;
            dec_reg    <= 1'b0;
            subkey_reg <= '0;
        end else begin
            state_reg <= state_next;
            cd_reg    <= cd_next;
            step_reg  <= step_next;
            idx_reg   <= idx_next;
            dec_reg   <= dec_next;
            if (clear_sub) begin
                subkey_reg <= '0;
            end else if (load_sub) begin
                subkey_reg <= pc2_sub;
            end
        end
    end

    assign subkey_out   = subkey_reg;
    assign round_idx    = idx_reg;
    assign subkey_valid = (state_reg == ISSUE);
    assign busy         = (state_reg == ISSUE);
    assign done         = (state_reg == DONE);

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: scoreboard of model subkeys,
// stall stability, ignored restarts, mid-run reset and parity-bit independence.
module tb_des_key_schedule;

    localparam logic [63:0] KEY1    = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_PAR = 64'h123557799BBCDFF0;
    localparam logic [47:0] K1_C    = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_C    = 48'h79AED9DBC9E5;
    localparam logic [47:0] K15_C   = 48'hBF918D3D3F0A;
    localparam logic [47:0] K16_C   = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [0:63] key_in = '0;
    logic        advance = 1'b0;
    logic [0:47] subkey_out;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [51:0] sb_q [$];

    des_key_schedule #(.NUM_ROUNDS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .advance      (advance),
        .subkey_out   (subkey_out),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] model_pc1(input logic [63:0] key);
        logic [55:0] cd;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64 - PC1_T[i]];
        return cd;
    endfunction

    // Kr computed directly from C0/D0 rotated by the cumulative shift count.
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int r);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] k;
        int tot;
        tot = 0;
        for (int n = 1; n <= r; n++) tot += (n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2;
        cd = model_pc1(key);
        c  = cd[55:28];
        d  = cd[27:0];
        for (int n = 0; n < tot; n++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56 - PC2_T[i]];
        return k;
    endfunction

    task automatic run(input string name, input logic [63:0] key, input logic dec,
                       input logic [63:0] model_key, input int stall_pct,
                       input int restart_at, input int rst_at);
        int acc;
        int cyc;
        int done_cnt;
        bit have_prev;
        bit restarted;
        logic adv;
        logic [47:0] prev_sub;
        logic [3:0]  prev_idx;
        logic [51:0] exp;
        logic [47:0] obs [16];
        for (int r = 1; r <= 16; r++) begin
            int rr;
            rr = dec ? 17 - r : r;
            sb_q.push_back({4'(rr - 1), model_subkey(model_key, rr)});
        end
        key_in = key; decrypt = dec; start = 1'b1; advance = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_valid_t1"}, 64'(subkey_valid), 64'd1);
        chk({name, "_busy_t1"}, 64'(busy), 64'd1);
        acc = 0; done_cnt = 0; have_prev = 0; restarted = 0;
        prev_sub = '0; prev_idx = '0;
        for (int i = 0; i < 16; i++) obs[i] = '0;
        for (cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
            if (rst_at >= 0 && acc == rst_at) begin
                rst = 1'b1; advance = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                chk({name, "_rst_valid"}, 64'(subkey_valid), 64'd0);
                chk({name, "_rst_busy"}, 64'(busy), 64'd0);
                chk({name, "_rst_subkey"}, 64'(subkey_out), 64'd0);
                chk({name, "_rst_idx"}, 64'(round_idx), 64'd0);
                sb_q.delete();
                return;
            end
            chk({name, "_valid"}, 64'(subkey_valid), 64'd1);
            if (have_prev) begin
                chk({name, "_stall_subkey"}, 64'(subkey_out), 64'(prev_sub));
                chk({name, "_stall_idx"}, 64'(round_idx), 64'(prev_idx));
            end
            adv = ($urandom_range(99) >= 32'(stall_pct));
            if (restart_at >= 0 && acc == restart_at && !restarted) begin
                start = 1'b1; key_in = ~key; decrypt = ~dec; restarted = 1;
            end
            if (adv) begin
                chk({name, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    chk({name, "_subkey"}, 64'(subkey_out), 64'(exp[47:0]));
                    chk({name, "_round_idx"}, 64'(round_idx), 64'(exp[51:48]));
                end
                $display("%s round=%0d subkey=%h", name, 32'(round_idx) + 1, subkey_out);
                if (acc < 16) obs[acc] = subkey_out;
                acc++;
                have_prev = 0;
            end else begin
                have_prev = 1;
                prev_sub  = subkey_out;
                prev_idx  = round_idx;
            end
            advance = adv;
            @(posedge clk); #1;
            start = 1'b0;
            advance = 1'b0;
            if (done) done_cnt++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt), 64'd1);
        if (stall_pct == 0) chk({name, "_latency"}, 64'(cyc), 64'd16);
        chk({name, "_done_busy"}, 64'(busy), 64'd0);
        chk({name, "_done_valid"}, 64'(subkey_valid), 64'd0);
        chk({name, "_done_subkey"}, 64'(subkey_out), 64'd0);
        chk({name, "_shadow_cd"}, 64'(dut.cd_reg), 64'(model_pc1(model_key)));
        chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        chk({name, "_first"}, 64'(obs[0]), dec ? 64'(K16_C) : 64'(K1_C));
        chk({name, "_second"}, 64'(obs[1]), dec ? 64'(K15_C) : 64'(K2_C));
        chk({name, "_last"}, 64'(obs[15]), dec ? 64'(K1_C) : 64'(K16_C));
        // A start landing in DONE must be dropped.
        start = 1'b1; key_in = ~key;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_done_pulse_len"}, 64'(done), 64'd0);
        chk({name, "_start_in_done_busy"}, 64'(busy), 64'd0);
        chk({name, "_start_in_done_valid"}, 64'(subkey_valid), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(subkey_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_subkey", 64'(subkey_out), 64'd0);
        chk("reset_idx", 64'(round_idx), 64'd0);
        rst = 1'b0;
        advance = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        advance = 1'b0;
        chk("idle_advance_valid", 64'(subkey_valid), 64'd0);
        chk("idle_advance_busy", 64'(busy), 64'd0);

        run("enc",       KEY1,    1'b0, KEY1, 0,  -1, -1);
        run("dec",       KEY1,    1'b1, KEY1, 0,  -1, -1);
        run("enc_stall", KEY1,    1'b0, KEY1, 40, -1, -1);
        run("dec_stall", KEY1,    1'b1, KEY1, 40, -1, -1);
        run("parity",    KEY_PAR, 0,    KEY1, 25, -1, -1);
        run("restart",   KEY1,    1'b0, KEY1, 0,  5,  -1);
        run("mid_rst",   KEY1,    1'b0, KEY1, 0,  -1, 7);
        run("after_rst", KEY1,    1'b0, KEY1, 0,  -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Iterative DES subkey generator that sits directly upstream of the Feistel S-box stage. It loads a 64-bit key and emits the sixteen 48-bit round subkeys K1..K16, one per handshake. The round datapath XORs each subkey with the expanded R half and splits the result into the 6-bit S-box inputs. It supports encrypt order (K1 first) and decrypt order (K16 first), using reverse rotations so no subkey storage is needed.

Parameters:
NUM_ROUNDS, 16, rounds per key; fixed by DES; legal value 16 only.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to load key_in and begin a schedule; honoured only in IDLE
decrypt  input  1  sampled with start; 0 = emit K1..K16, 1 = emit K16..K1
key_in  input  [0:63]  DES key; index 0 = DES bit 1; parity bits 8,16,..,64 ignored
advance  input  1  consumer accepts the current subkey
subkey_out  output  [0:47]  current round subkey; index 0 = DES bit 1, feeding S1 input bits 0..5
subkey_valid  output  1  subkey_out and round_idx are valid
round_idx  output  [3:0]  round number of subkey_out minus 1 (K1 -> 0, K16 -> 15)
busy  output  1  schedule in progress (ISSUE state)
done  output  1  one-cycle pulse after the final subkey is accepted

Behaviour:
- Reset: state IDLE; C, D, subkey_out, round_idx and the step counter are all 0; subkey_valid, busy and done are 0. Reset mid-schedule aborts it, and the next start begins fresh.
- Shift schedule s[r] for r = 1..16: 1 at r = 1, 2, 9, 16; 2 otherwise. Total rotation is 28.
- States: IDLE, ISSUE, DONE.
- IDLE, start=1 at cycle t: {C,D} <= PC1(key_in) (28 + 28 bits); decrypt is latched; step j <= 1.
  - Encrypt: C,D rotate left by s[1]; subkey_out <= PC2(rotated C,D), which is K1.
  - Decrypt: no rotation; subkey_out <= PC2(C0,D0), which is K16.
  - At cycle t+1: subkey_valid=1, busy=1, state ISSUE.
- IDLE with advance=1 and no start: no effect.
- ISSUE, subkey_valid && advance, j < 16: j increments and the next subkey is registered, visible the following cycle (one subkey per cycle at full throughput).
  - Encrypt step j+1: rotate left by s[j+1]; emit K(j+1).
  - Decrypt step j+1: rotate right by s[18-(j+1)]; emit K(16-j).
  - round_idx tracks the emitted round number minus 1.
- ISSUE, advance=0: all outputs hold stable. Stall length is unbounded.
- ISSUE, advance=1 with j = 16: state DONE. subkey_valid, busy and subkey_out all go to 0.
- DONE: done=1 for exactly one cycle, then IDLE. A start arriving in DONE is ignored.
- start while busy or in DONE: ignored; key_in and decrypt are not resampled.
- Simultaneous start and rst: rst wins.
- After 16 encrypt steps C,D have rotated 28 and equal C0,D0. The decrypt path's final state is also C0,D0. A shadow check must confirm this in simulation.
- Bit numbering is DES-standard, MSB-first. PC1 and PC2 tables use 1-based DES numbering mapped to index-1.

Decomposition:
- Shared package des_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries)
  - SHIFT_SCHED[1:16]
  - state enum {IDLE, ISSUE, DONE}
  - widths KEY_W=64, CD_W=28, SUBKEY_W=48
- One natural sub-module: des_pc2, a pure combinational 56->48 permutation instanced once on the next-{C,D} value.
- PC1 is used once and stays inline.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, start, advance held 1 -> subkey_valid at t+1, K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, K16=0xCB3D8B0E17F5 at t+16, done pulse at t+17, busy low at t+17.
- Same key, decrypt=1 -> first subkey 0xCB3D8B0E17F5 with round_idx=15; second 0x(K15) matches the encrypt-run K15; last 0x1B02EFFC7072 with round_idx=0.
- Random advance stalls, encrypt run -> subkey_out and round_idx stable throughout every stall; 16 distinct subkeys identical to the no-stall run; exactly one done.
- Parity-bit flip (key 0x123557799BBCDFF0 vs 0x133457799BBCDFF1 differing only in bits 8/16/..) -> identical 16-subkey sequence.
- start pulsed again at step 5 with a different key -> ignored; sequence continues with the original key.
- rst asserted at step 7 -> next cycle subkey_valid=0, busy=0, subkey_out=0; a subsequent start reproduces K1 exactly.
